// File: rtl/io_port_unit.sv
// I/O responder for in/out: input FIFO plus held output word with valid/ack.
// Define IO_PORT_STATUS_EN to build the sticky underflow/overrun flags.
module io_port_unit #(
  parameter int DATA_W   = 16,
  parameter int IN_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        OutputWrite,
  input  logic                        InRead,
  input  logic [DATA_W-1:0]           WriteData,
  output logic [DATA_W-1:0]           ReadData,
  input  logic [DATA_W-1:0]           ext_in_data,
  input  logic                        ext_in_valid,
  output logic                        ext_in_ready,
  output logic [DATA_W-1:0]           ext_out_data,
  output logic                        ext_out_valid,
  input  logic                        ext_out_ack,
  output logic [$clog2(IN_DEPTH):0]   in_count,
  output logic                        in_underflow,
  output logic                        out_overrun
);

  localparam int PW = $clog2(IN_DEPTH);
  localparam int CW = PW + 1;

  localparam logic OUT_IDLE = 1'b0;
  localparam logic OUT_PEND = 1'b1;

  logic [DATA_W-1:0] mem [IN_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic              empty;

  logic              state;
  logic [DATA_W-1:0] out_q;

  assign empty        = (in_count == '0);
  assign ext_in_ready = (in_count != CW'(IN_DEPTH));
  assign push         = ext_in_valid && ext_in_ready;
  assign pop          = InRead && !empty;
  assign ReadData     = empty ? '0 : mem[rd_ptr];

  // storage is deliberately left unreset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= ext_in_data;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      in_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        in_count <= in_count + 1'b1;
      end else if (pop && !push) begin
        in_count <= in_count - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= OUT_IDLE;
      out_q <= '0;
    end else begin
      if (OutputWrite) begin
        state <= OUT_PEND;
        out_q <= WriteData;
      end else if (state == OUT_PEND && ext_out_ack) begin
        state <= OUT_IDLE;
      end
    end
  end

  assign ext_out_valid = (state == OUT_PEND);
  assign ext_out_data  = out_q;

`ifdef IO_PORT_STATUS_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      in_underflow <= 1'b0;
      out_overrun  <= 1'b0;
    end else begin
      if (InRead && empty) begin
        in_underflow <= 1'b1;
      end
      if (state == OUT_PEND && OutputWrite && !ext_out_ack) begin
        out_overrun <= 1'b1;
      end
    end
  end
`else
  assign in_underflow = 1'b0;
  assign out_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: FIFO order, wrap, underflow, handshake.
module tb_io_port_unit;

`ifdef IO_PORT_STATUS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        OutputWrite = 1'b0;
  logic        InRead = 1'b0;
  logic [15:0] WriteData = '0;
  logic [15:0] ReadData;
  logic [15:0] ext_in_data = '0;
  logic        ext_in_valid = 1'b0;
  logic        ext_in_ready;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ack = 1'b0;
  logic [2:0]  in_count;
  logic        in_underflow;
  logic        out_overrun;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  io_port_unit dut (
    .CLK(CLK),
    .Reset(Reset),
    .OutputWrite(OutputWrite),
    .InRead(InRead),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .ext_in_data(ext_in_data),
    .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data),
    .ext_out_valid(ext_out_valid),
    .ext_out_ack(ext_out_ack),
    .in_count(in_count),
    .in_underflow(in_underflow),
    .out_overrun(out_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    OutputWrite  = 1'b0;
    InRead       = 1'b0;
    ext_in_valid = 1'b0;
    ext_out_ack  = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    edge_step();
    edge_step();
    @(negedge CLK);
    Reset = 1'b1;

    // mid-transfer activity, then async reset
    @(negedge CLK);
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0abc;
    OutputWrite  = 1'b1;
    WriteData    = 16'haaaa;
    edge_step();
    idle_in();
    chk("pre_rst_valid", ext_out_valid, 1);
    chk("pre_rst_cnt", in_count, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_ready", ext_in_ready, 1);
    chk("rst_valid", ext_out_valid, 0);
    chk("rst_odata", ext_out_data, 0);
    chk("rst_cnt", in_count, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_uf", in_underflow, 0);
    chk("rst_ov", out_overrun, 0);
    @(negedge CLK);
    Reset = 1'b1;

    // fill
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      ext_in_valid = 1'b1;
      ext_in_data  = 16'(i * 16'h0011);
      edge_step();
      ext_in_valid = 1'b0;
      chk("fill_cnt", in_count, i);
      chk("fill_head", ReadData, 16'h0011);
    end
    chk("full_ready", ext_in_ready, 0);
    @(negedge CLK);
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0099;
    edge_step();
    ext_in_valid = 1'b0;
    chk("full_reject", in_count, 4);

    // pop at full with push offered: not accepted
    @(negedge CLK);
    InRead       = 1'b1;
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0055;
    #1;
    chk("pop_full_ready", ext_in_ready, 0);
    chk("drain0", ReadData, 16'h0011);
    edge_step();
    idle_in();
    chk("pop_full_cnt", in_count, 3);
    chk("pop_full_ready2", ext_in_ready, 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge CLK);
      InRead = 1'b1;
      #1;
      chk("drain", ReadData, 16'(i * 16'h0011));
      edge_step();
      InRead = 1'b0;
    end
    chk("drain_cnt", in_count, 0);
    chk("drain_rdata", ReadData, 0);
    chk("drain_uf", in_underflow, 0);

    // wrap with simultaneous push/pop at count 1
    @(negedge CLK);
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0101;
    edge_step();
    ext_in_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge CLK);
      ext_in_valid = 1'b1;
      ext_in_data  = 16'(16'h0100 + i);
      InRead       = 1'b1;
      #1;
      chk("wrap_head", ReadData, 16'(16'h0100 + i - 1));
      edge_step();
      idle_in();
      chk("wrap_cnt", in_count, 1);
    end
    @(negedge CLK);
    InRead = 1'b1;
    #1;
    chk("wrap_last", ReadData, 16'h0106);
    edge_step();
    InRead = 1'b0;
    chk("wrap_empty", in_count, 0);

    // underflow
    @(negedge CLK);
    InRead = 1'b1;
    #1;
    chk("uf_rdata", ReadData, 0);
    edge_step();
    InRead = 1'b0;
    chk("uf_cnt", in_count, 0);
    chk("uf_flag", in_underflow, FLG);

    // push and read on empty: no bypass, word kept
    @(negedge CLK);
    InRead       = 1'b1;
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0777;
    #1;
    chk("nobypass", ReadData, 0);
    edge_step();
    idle_in();
    chk("nobypass_cnt", in_count, 1);
    chk("nobypass_word", ReadData, 16'h0777);
    @(negedge CLK);
    InRead = 1'b1;
    edge_step();
    InRead = 1'b0;
    chk("nobypass_pop", in_count, 0);

    // output handshake
    @(negedge CLK);
    OutputWrite = 1'b1;
    WriteData   = 16'hbeef;
    edge_step();
    OutputWrite = 1'b0;
    chk("out_valid", ext_out_valid, 1);
    chk("out_data", ext_out_data, 16'hbeef);
    @(negedge CLK);
    ext_out_ack = 1'b1;
    edge_step();
    ext_out_ack = 1'b0;
    chk("ack_drop", ext_out_valid, 0);
    @(negedge CLK);
    ext_out_ack = 1'b1;
    edge_step();
    ext_out_ack = 1'b0;
    chk("idle_ack", ext_out_valid, 0);

    // collision with ack: no overrun
    @(negedge CLK);
    OutputWrite = 1'b1;
    WriteData   = 16'h1234;
    edge_step();
    @(negedge CLK);
    WriteData   = 16'h5678;
    ext_out_ack = 1'b1;
    edge_step();
    idle_in();
    chk("col_ack_valid", ext_out_valid, 1);
    chk("col_ack_data", ext_out_data, 16'h5678);
    chk("col_ack_ov", out_overrun, 0);

    // collision without ack: overrun
    @(negedge CLK);
    OutputWrite = 1'b1;
    WriteData   = 16'h9abc;
    edge_step();
    OutputWrite = 1'b0;
    chk("col_data", ext_out_data, 16'h9abc);
    chk("col_valid", ext_out_valid, 1);
    chk("col_ov", out_overrun, FLG);
    chk("uf_sticky", in_underflow, FLG);

    // reset clears sticky flags and pending word
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("rst2_uf", in_underflow, 0);
    chk("rst2_ov", out_overrun, 0);
    chk("rst2_valid", ext_out_valid, 0);
    @(negedge CLK);
    Reset = 1'b1;
    edge_step();
    chk("rst2_ready", ext_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
